root_write_burst_buffer: RTL and testbench

//  Root-side sink of a merge tree: accepts sorted {last, data} bundles from the root merge logic,

---
 rtl/root_write_burst_buffer_if.sv | 39 +++
 rtl/root_write_burst_buffer.sv | 141 ++++++++++++++
 tb/tb_root_write_burst_buffer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/root_write_burst_buffer_if.sv
// Bundle, control and memory write-channel signals of the root write burst buffer.
// The buffer takes the master view; the memory/tree side takes the slave view.
interface root_write_burst_buffer_if #(
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned BundleWidth = 8,
  parameter int unsigned AddrWidth   = 64
);
  localparam int unsigned BeatWidth = BundleWidth * DataWidth;

  logic                 start;
  logic [AddrWidth-1:0] base_addr;
  logic [BeatWidth:0]   root_data;
  logic                 root_data_vld;
  logic                 root_read;
  logic                 wr_req_vld;
  logic [AddrWidth-1:0] wr_req_addr;
  logic [7:0]           wr_req_len;
  logic                 wr_req_rdy;
  logic [BeatWidth-1:0] wr_data;
  logic                 wr_data_vld;
  logic                 wr_data_last;
  logic                 wr_data_rdy;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [31:0]          beat_cnt;

  modport master (
    input  start, base_addr, root_data, root_data_vld, wr_req_rdy, wr_data_rdy,
    output root_read, wr_req_vld, wr_req_addr, wr_req_len, wr_data, wr_data_vld,
           wr_data_last, busy, done, err, beat_cnt
  );

  modport slave (
    output start, base_addr, root_data, root_data_vld, wr_req_rdy, wr_data_rdy,
    input  root_read, wr_req_vld, wr_req_addr, wr_req_len, wr_data, wr_data_vld,
           wr_data_last, busy, done, err, beat_cnt
  );
endinterface

// File: rtl/root_write_burst_buffer.sv
// Root sink of a merge tree: FWFT bundle FIFO drained as fixed-length write bursts,
// with a shortened final burst once the last-flagged bundle has been buffered.
module root_write_burst_buffer #(
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned BundleWidth = 8,
  parameter int unsigned FifoDepth   = 64,
  parameter int unsigned BurstLen    = 16,
  parameter int unsigned Slack       = 11,
  parameter int unsigned AddrWidth   = 64
) (
  input logic                    i_clk,
  input logic                    i_rst,
  root_write_burst_buffer_if.master bus
);

  localparam int unsigned BeatWidth = BundleWidth * DataWidth;
  localparam int unsigned BeatBytes = BeatWidth / 8;
  localparam int unsigned PtrW      = $clog2(FifoDepth);
  localparam int unsigned CntW      = PtrW + 1;
  localparam int unsigned LenW      = 9;

  localparam logic [CntW-1:0] Depth     = CntW'(FifoDepth);
  localparam logic [CntW-1:0] Threshold = CntW'(FifoDepth - Slack);
  localparam logic [CntW-1:0] BurstCnt  = CntW'(BurstLen);

  typedef enum logic [2:0] {StIdle, StWait, StReq, StData, StDone} state_e;

  state_e               state_q, state_d;
  logic [BeatWidth-1:0] mem_q [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic                 last_seen_q, last_seen_d;
  logic                 err_q;
  logic                 root_read_q, root_read_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [LenW-1:0]      len_q, len_d;
  logic [LenW-1:0]      beats_left_q, beats_left_d;
  logic [31:0]          beat_cnt_q, beat_cnt_d;
  logic                 push, pop, drop;

  // Writes outside a run, after the last bundle, or into a full FIFO are discarded.
  assign push = bus.root_data_vld && (state_q != StIdle) && !last_seen_q && (count_q != Depth);
  assign drop = bus.root_data_vld && !push;
  assign pop  = (state_q == StData) && bus.wr_data_rdy;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    beats_left_d = beats_left_q;
    beat_cnt_d   = beat_cnt_q;
    last_seen_d  = last_seen_q | (push & bus.root_data[BeatWidth]);
    count_d      = count_q + CntW'(push) - CntW'(pop);
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d     = StWait;
          addr_d      = bus.base_addr;
          beat_cnt_d  = '0;
          last_seen_d = 1'b0;
        end
      end
      StWait: begin
        if (count_q >= BurstCnt) begin
          len_d   = LenW'(BurstLen);
          state_d = StReq;
        end else if (last_seen_q && (count_q != '0)) begin
          len_d   = LenW'(count_q);
          state_d = StReq;
        end else if (last_seen_q) begin
          state_d = StDone;
        end
      end
      StReq: begin
        if (bus.wr_req_rdy) begin
          addr_d       = addr_q + AddrWidth'(len_q) * AddrWidth'(BeatBytes);
          beats_left_d = len_q;
          state_d      = StData;
        end
      end
      StData: begin
        if (bus.wr_data_rdy) begin
          beat_cnt_d   = beat_cnt_q + 32'd1;
          beats_left_d = beats_left_q - LenW'(1);
          if (beats_left_q == LenW'(1)) state_d = StWait;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    root_read_d = (state_d != StIdle) && !last_seen_d && (count_d < Threshold);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_seen_q  <= 1'b0;
      err_q        <= 1'b0;
      root_read_q  <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      beats_left_q <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_q + PtrW'(push);
      rd_ptr_q     <= rd_ptr_q + PtrW'(pop);
      count_q      <= count_d;
      last_seen_q  <= last_seen_d;
      err_q        <= err_q | drop;
      root_read_q  <= root_read_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      beats_left_q <= beats_left_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.root_data[BeatWidth-1:0];
  end

  always_comb begin
    bus.root_read    = root_read_q;
    bus.wr_req_vld   = (state_q == StReq);
    bus.wr_req_addr  = addr_q;
    bus.wr_req_len   = (state_q == StReq) ? 8'(len_q - LenW'(1)) : 8'd0;
    bus.wr_data_vld  = (state_q == StData);
    bus.wr_data      = (state_q == StData) ? mem_q[rd_ptr_q] : '0;
    bus.wr_data_last = (state_q == StData) && (beats_left_q == LenW'(1));
    bus.busy         = (state_q != StIdle);
    bus.done         = (state_q == StDone);
    bus.err          = err_q;
    bus.beat_cnt     = beat_cnt_q;
  end

endmodule

// File: tb/tb_root_write_burst_buffer.sv
// Directed bench for root_write_burst_buffer: tree model with configurable push latency,
// write-channel sink with stalls, and a scoreboard of bursts and beat data.
module tb_root_write_burst_buffer;
  localparam int unsigned DW = 64;
  localparam int unsigned BW = 8;
  localparam int unsigned AW = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  root_write_burst_buffer_if #(.DataWidth(DW), .BundleWidth(BW), .AddrWidth(AW)) bus ();

  root_write_burst_buffer #(
    .DataWidth(DW), .BundleWidth(BW), .FifoDepth(64), .BurstLen(16), .Slack(11), .AddrWidth(AW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_miscmp = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] pat(input int run_id, input int i);
    logic [511:0] v;
    for (int j = 0; j < 8; j++) v[j*64 +: 64] = {32'hC0DE_0000 + 32'(run_id), 16'(j), 16'(i)};
    return v;
  endfunction

  int cyc, sent, beats_seen, reqs_seen, done_cnt, outstanding;
  int model_cnt, max_cnt, fall_cnt, push16_cyc, first_req_cyc;
  logic [15:0] pipe;
  logic rr_prev;

  // One run: called at a negedge; each iteration samples outputs, then drives inputs.
  task automatic run(input int id, input int n, input int d, input logic [63:0] base,
                     input int req_stall, input int data_stall, input int inject_at,
                     input bit poke, input int abort_at, output bit aborted);
    int stall_left;
    int since_done;
    int exp_len;
    stall_left = req_stall;
    since_done = 0;
    aborted = 1'b0;
    sent = 0; beats_seen = 0; reqs_seen = 0; done_cnt = 0; outstanding = 0;
    model_cnt = 0; max_cnt = 0; fall_cnt = -1; push16_cyc = -1; first_req_cyc = -1;
    pipe = '0; rr_prev = 1'b0;
    cyc = 0;
    while (cyc < 4000) begin
      exp_len = (reqs_seen < n / 16) ? 16 : n % 16;
      if (rr_prev && !bus.root_read && fall_cnt < 0) fall_cnt = model_cnt;
      rr_prev = bus.root_read;
      if (bus.wr_req_vld && first_req_cyc < 0) first_req_cyc = cyc;
      if (bus.wr_req_vld) begin
        check_eq("req_addr", bus.wr_req_addr, base + 64'(reqs_seen) * 64'd1024);
        check_eq("req_len", bus.wr_req_len, exp_len - 1);
      end
      if (bus.wr_data_vld) check_eq("beat_before_req", outstanding > 0, 1'b1);
      if (inject_at >= 0 && cyc == inject_at) check_eq("err_before_drop", bus.err, 1'b0);
      if (inject_at >= 0 && cyc == inject_at + 2) check_eq("err_after_drop", bus.err, 1'b1);

      bus.start     = (cyc == 0) || (poke && cyc == 10);
      bus.base_addr = (cyc == 0) ? base : 64'hDEAD_BEE0_0000_0400;
      bus.wr_req_rdy = 1'b1;
      if (bus.wr_req_vld && stall_left > 0) begin
        bus.wr_req_rdy = 1'b0;
        stall_left--;
      end
      bus.wr_data_rdy = (cyc >= data_stall);
      pipe = {pipe[14:0], bus.root_read};
      if (inject_at >= 0 && cyc == inject_at) begin
        bus.root_data_vld = 1'b1;
        bus.root_data     = {1'b0, {512{1'b1}}};
      end else if (pipe[d] && sent < n) begin
        bus.root_data_vld = 1'b1;
        bus.root_data     = {sent == n - 1, pat(id, sent)};
        sent++;
        model_cnt++;
        if (sent == 16) push16_cyc = cyc;
      end else begin
        bus.root_data_vld = 1'b0;
      end

      if (bus.wr_data_vld && bus.wr_data_rdy) begin
        check_eq("beat_data", bus.wr_data, pat(id, beats_seen));
        check_eq("beat_last", bus.wr_data_last, outstanding == 1);
        outstanding--;
        beats_seen++;
        model_cnt--;
      end
      if (bus.wr_req_vld && bus.wr_req_rdy) begin
        outstanding = exp_len;
        reqs_seen++;
      end
      if (model_cnt > max_cnt) max_cnt = model_cnt;
      if (bus.done) done_cnt++;
      if (done_cnt > 0) since_done++;
      if (abort_at > 0 && beats_seen == abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (since_done > 5) break;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    bus.root_data_vld = 1'b0;
  endtask

  task automatic final_checks(input string tag, input int n, input bit exp_err);
    int n_req;
    n_req = n / 16 + ((n % 16) != 0 ? 1 : 0);
    check_eq({tag, "_done_once"}, done_cnt, 1);
    check_eq({tag, "_beats"}, beats_seen, n);
    check_eq({tag, "_beat_cnt"}, bus.beat_cnt, n);
    check_eq({tag, "_reqs"}, reqs_seen, n_req);
    check_eq({tag, "_err"}, bus.err, exp_err);
    check_eq({tag, "_busy"}, bus.busy, 1'b0);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_root_read"}, bus.root_read, 1'b0);
    check_eq({tag, "_req_vld"}, bus.wr_req_vld, 1'b0);
    check_eq({tag, "_req_addr"}, bus.wr_req_addr, 64'd0);
    check_eq({tag, "_req_len"}, bus.wr_req_len, 8'd0);
    check_eq({tag, "_data"}, bus.wr_data, 512'd0);
    check_eq({tag, "_data_vld"}, bus.wr_data_vld, 1'b0);
    check_eq({tag, "_data_last"}, bus.wr_data_last, 1'b0);
    check_eq({tag, "_busy"}, bus.busy, 1'b0);
    check_eq({tag, "_done"}, bus.done, 1'b0);
    check_eq({tag, "_err"}, bus.err, 1'b0);
    check_eq({tag, "_beat_cnt"}, bus.beat_cnt, 32'd0);
  endtask

  initial begin
    bit ab;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.root_data = '0;
    bus.root_data_vld = 1'b0;
    bus.wr_req_rdy = 1'b0;
    bus.wr_data_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    // Two full bursts, plus first-request latency.
    run(1, 32, 0, 64'h1000_0000, 0, 0, -1, 1'b0, 0, ab);
    final_checks("t1", 32, 1'b0);
    check_eq("t1_req_latency", first_req_cyc - push16_cyc, 2);

    // Short final burst; a start pulse mid-run must be ignored.
    run(2, 20, 0, 64'h2000_0400, 0, 0, -1, 1'b1, 0, ab);
    final_checks("t2", 20, 1'b0);

    // Request channel stalled for 10 cycles.
    run(6, 16, 0, 64'h3000_0000, 10, 0, -1, 1'b0, 0, ab);
    final_checks("t6", 16, 1'b0);

    // Write channel stalled 200 cycles against an 11-cycle tree; drop one into a full FIFO.
    run(3, 80, 11, 64'h4000_0000, 0, 200, 150, 1'b0, 0, ab);
    final_checks("t3", 80, 1'b1);
    check_eq("t3_fall_count", fall_cnt, 53);
    check_eq("t3_max_fill", max_cnt, 64);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_quiet("reset2");

    // Bundle pushed while idle.
    bus.root_data_vld = 1'b1;
    bus.root_data = {1'b1, {512{1'b1}}};
    @(negedge clk);
    bus.root_data_vld = 1'b0;
    check_eq("idle_drop_err", bus.err, 1'b1);
    check_eq("idle_drop_busy", bus.busy, 1'b0);
    run(4, 16, 0, 64'h5000_0000, 0, 0, -1, 1'b0, 0, ab);
    final_checks("t4", 16, 1'b1);

    // Reset in the middle of a burst, then a clean run.
    run(5, 32, 0, 64'h6000_0000, 0, 0, -1, 1'b0, 4, ab);
    check_eq("t5_aborted", ab, 1'b1);
    @(negedge clk);
    check_eq("t5_beat5_vld", bus.wr_data_vld, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("t5_reset");
    rst = 1'b0;
    @(negedge clk);
    run(7, 20, 0, 64'h7000_0000, 0, 0, -1, 1'b0, 0, ab);
    final_checks("t5_rerun", 20, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule
